// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: control-word inputs and sequencer outputs shared by the
// micro sequencer (slave) and whatever drives it (master).
interface micro_sequencer_if #(
    parameter int AW = 8
);
    logic          start;
    logic          stall;
    logic [1:0]    bs;
    logic          ps;
    logic          z;
    logic [AW-1:0] bra;
    logic [AW-1:0] raa;
    logic          halt_i;
    logic          call_i;
    logic          ret_i;
    logic [AW-1:0] car;
    logic [1:0]    mux_c_sel;
    logic          busy;
    logic          done;
    logic          stk_err;

    modport master (
        output start, stall, bs, ps, z, bra, raa, halt_i, call_i, ret_i,
        input  car, mux_c_sel, busy, done, stk_err
    );

    modport slave (
        input  start, stall, bs, ps, z, bra, raa, halt_i, call_i, ret_i,
        output car, mux_c_sel, busy, done, stk_err
    );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: IDLE/RUN/DONE control-address sequencer with conditional branching.
// Define MSEQ_CALL_STACK_EN to add a STACK_DEPTH-entry call/return stack.
module micro_sequencer #(
    parameter int            AW          = 8,
    parameter logic [AW-1:0] RESET_ADDR  = '0,
    parameter int            STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    micro_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [AW-1:0] car_q, car_n, inc, nxt;
    logic [1:0]    sel;
    logic          adv, done_q;

    assign inc = car_q + AW'(1);
    assign adv = (state == RUN) && !bus.stall && !bus.halt_i;

`ifdef MSEQ_CALL_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0]  stack [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic           err_q, empty, full, push, pop, ovf;

    assign empty = (sp == '0);
    assign full  = (sp == SPW'(STACK_DEPTH));
    assign push  = adv && !bus.ret_i && bus.call_i && !full;
    assign pop   = adv && bus.ret_i && !empty;
    assign ovf   = adv && (bus.ret_i ? empty : (bus.call_i && full));

    // ret wins over call, call wins over the branch select
    always_comb begin
        sel = 2'b00;
        if (state == RUN)
            sel = bus.ret_i  ? (empty ? 2'b00 : 2'b11) :
                  bus.call_i ? 2'b01 :
                  (bus.bs == 2'b10) ? 2'b10 :
                  ((bus.bs == 2'b11) || (bus.bs == 2'b01 && (bus.z ^ bus.ps))) ? 2'b01 : 2'b00;
    end

    assign nxt = (sel == 2'b11) ? stack[IW'(sp - SPW'(1))] :
                 (sel == 2'b10) ? bus.raa :
                 (sel == 2'b01) ? bus.bra : inc;

    always_ff @(posedge clk)
        if (push) stack[IW'(sp)] <= inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            sp    <= push ? sp + SPW'(1) : pop ? sp - SPW'(1) : sp;
            err_q <= err_q | ovf;
        end
    end

    assign bus.stk_err = err_q;
`else
    always_comb begin
        sel = 2'b00;
        if (state == RUN)
            sel = (bus.bs == 2'b10) ? 2'b10 :
                  ((bus.bs == 2'b11) || (bus.bs == 2'b01 && (bus.z ^ bus.ps))) ? 2'b01 : 2'b00;
    end

    assign nxt = (sel == 2'b10) ? bus.raa : (sel == 2'b01) ? bus.bra : inc;
    assign bus.stk_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        car_n   = car_q;
        case (state)
            IDLE: if (bus.start) state_n = RUN;
            RUN:
                if (!bus.stall) begin
                    if (bus.halt_i) state_n = DONE;
                    else car_n = nxt;
                end
            DONE: begin
                state_n = IDLE;
                car_n   = RESET_ADDR;
            end
            default: begin
                state_n = IDLE;
                car_n   = RESET_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            car_q  <= RESET_ADDR;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            car_q  <= car_n;
            done_q <= (state_n == DONE);
        end
    end

    assign bus.car       = car_q;
    assign bus.mux_c_sel = sel;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and random stimulus against a queue-based
// reference model of the sequencer's address rules.
module tb_micro_sequencer;
    localparam int AW    = 8;
    localparam int MOD   = 2 ** AW;
    localparam int DEPTH = 4;
`ifdef MSEQ_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    micro_sequencer_if #(.AW(AW)) bus ();
    micro_sequencer #(.AW(AW), .RESET_ADDR('0), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int m_car = 0;
    bit m_run, m_done, m_err;
    int stk[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_sel();
        if (!m_run) return 0;
        if (STK && bus.ret_i) return (stk.size() > 0) ? 3 : 0;
        if (STK && bus.call_i) return 1;
        case (bus.bs)
            2'd0: return 0;
            2'd1: return (bus.z != bus.ps) ? 1 : 0;
            2'd2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int next_addr();
        if (STK && bus.ret_i) begin
            if (stk.size() > 0) return stk.pop_back();
            m_err = 1'b1;
            return (m_car + 1) % MOD;
        end
        if (STK && bus.call_i) begin
            if (stk.size() < DEPTH) stk.push_back((m_car + 1) % MOD);
            else m_err = 1'b1;
            return int'(bus.bra);
        end
        case (bus.bs)
            2'd0: return (m_car + 1) % MOD;
            2'd1: return (bus.z != bus.ps) ? int'(bus.bra) : (m_car + 1) % MOD;
            2'd2: return int'(bus.raa);
            default: return int'(bus.bra);
        endcase
    endfunction

    task automatic check_outs();
        chk("car", bus.car, m_car);
        chk("busy", bus.busy, m_run || m_done);
        chk("done", bus.done, m_done);
        chk("stk_err", bus.stk_err, m_err);
    endtask

    // one clock of stimulus, entered and left at posedge+1
    task automatic cyc(input logic st, sl, input logic [1:0] b, input logic p, zz,
                       input int br, ra, input logic h, c, r);
        bus.start = st; bus.stall = sl; bus.bs = b; bus.ps = p; bus.z = zz;
        bus.bra = br[AW-1:0]; bus.raa = ra[AW-1:0];
        bus.halt_i = h; bus.call_i = c; bus.ret_i = r;
        #1;
        if (!m_run) chk("mux_c_sel_idle", bus.mux_c_sel, 0);
        else if (!sl && !h) chk("mux_c_sel", bus.mux_c_sel, exp_sel());
        if (!STK) chk("mux_c_sel_not_stack", bus.mux_c_sel == 2'b11, 0);
        if (m_done) begin
            m_done = 1'b0;
            m_car = 0;
        end else if (m_run) begin
            if (!sl) begin
                if (h) begin
                    m_run = 1'b0;
                    m_done = 1'b1;
                end else m_car = next_addr();
            end
        end else if (st) m_run = 1'b1;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic rst_seq();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.bs = 2'b11; bus.ps = 1'b0; bus.z = 1'b0;
        bus.bra = 8'h77; bus.raa = 8'h66; bus.halt_i = 1'b1; bus.call_i = 1'b0; bus.ret_i = 1'b0;
        #1;
        m_car = 0; m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        stk.delete();
        check_outs();
        chk("mux_c_sel_rst", bus.mux_c_sel, 0);
        @(posedge clk);
        #1;
        check_outs();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_seq();
        // start, then three increments
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("start_car", bus.car, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("inc3_car", bus.car, 3);
        chk("inc3_busy", bus.busy, 1);
        // conditional branch taken / not taken at 0x05
        cyc(0, 0, 3, 0, 0, 'h05, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 'h40, 0, 0, 0, 0);
        chk("cond_taken", bus.car, 'h40);
        cyc(0, 0, 3, 0, 0, 'h05, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 'h40, 0, 0, 0, 0);
        chk("cond_not_taken", bus.car, 'h06);
        cyc(0, 0, 1, 1, 0, 'h22, 0, 0, 0, 0);
        cyc(0, 0, 2, 0, 0, 0, 'h9A, 0, 0, 0);
        chk("raa_map", bus.car, 'h9A);
        // wrap and stall
        cyc(0, 0, 3, 0, 0, 'hFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap", bus.car, 0);
        cyc(0, 1, 3, 0, 0, 'h55, 0, 1, 0, 0);
        chk("stall_hold", bus.car, 0);
        // halt at 0x10
        cyc(0, 0, 3, 0, 0, 'h10, 0, 0, 0, 0);
        cyc(1, 0, 3, 0, 0, 'h20, 0, 1, 0, 0);
        chk("halt_done", bus.done, 1);
        chk("halt_car", bus.car, 'h10);
        cyc(1, 0, 3, 0, 0, 'h20, 0, 0, 0, 0);
        chk("after_done_car", bus.car, 0);
        chk("after_done_busy", bus.busy, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_stays", bus.busy, 0);
        // reset mid-RUN
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 'h33, 0, 0, 0, 0);
        rst_seq();
        chk("rst_no_done", bus.done, 0);
`ifdef MSEQ_CALL_STACK_EN
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 'h08, 0, 0, 0, 0);
        cyc(0, 0, 2, 0, 0, 'h30, 'h44, 0, 1, 0);
        chk("call_target", bus.car, 'h30);
        cyc(0, 0, 3, 0, 0, 'h70, 0, 0, 1, 1);
        chk("ret_target", bus.car, 'h09);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 'h50 + i, 0, 0, 1, 0);
        chk("overflow_err", bus.stk_err, 1);
        chk("overflow_car", bus.car, 'h54);
        rst_seq();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 3, 0, 0, 'h60, 0, 0, 0, 1);
        chk("underflow_car", bus.car, 2);
        chk("underflow_err", bus.stk_err, 1);
        rst_seq();
`endif
        for (int i = 0; i < 400; i++) begin
            if (i % 150 == 149) rst_seq();
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(0, MOD - 1)),
                int'($urandom_range(0, MOD - 1)), $urandom_range(0, 19) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
